// File: rtl/pio_cop_sequencer.sv
// rtl/pio_cop_sequencer.sv - PIO command/response handshake sequencer driving a coprocessor
module pio_cop_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [9:0] pio_cmd,
  output logic [9:0] pio_rsp,
  output logic       cop_start,
  output logic [2:0] cop_op,
  output logic [2:0] cop_addr,
  output logic [7:0] cop_wdata,
  input  logic       cop_done,
  input  logic [7:0] cop_rdata,
  input  logic       cop_err
);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_LO = 3'b001;
  localparam logic [2:0] OP_LOAD_HI = 3'b010;
  localparam logic [2:0] OP_EXEC    = 3'b011;
  localparam logic [2:0] OP_READ    = 3'b100;
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT} state_t;

  state_t     state, state_nxt;
  logic [9:0] cmd_q;
  logic       req_q;
  logic [2:0] op_q;
  logic [5:0] data_q;
  logic       ack, busy, err;
  logic [6:0] result;
  logic [7:0] rdata_q;
  logic [7:0] wait_cnt;
  logic       new_cmd, done_hit, timeout_hit, finish;

  assign pio_rsp   = {ack, busy, err, result};
  assign cop_start = (state == ISSUE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    new_cmd     = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_q[9] != ack) begin
          new_cmd   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (op_q == OP_EXEC) begin
          state_nxt = ISSUE;
        end else begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // a completion on the last allowed cycle still wins over the timeout
        done_hit    = cop_done;
        timeout_hit = !cop_done && (wait_cnt == WAIT_LAST);
        if (done_hit || timeout_hit) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q     <= '0;
      req_q     <= 1'b0;
      op_q      <= '0;
      data_q    <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      rdata_q   <= '0;
      wait_cnt  <= '0;
      cop_op    <= '0;
      cop_addr  <= '0;
      cop_wdata <= '0;
    end else begin
      cmd_q <= pio_cmd;
      if (new_cmd) begin
        req_q  <= cmd_q[9];
        op_q   <= cmd_q[8:6];
        data_q <= cmd_q[5:0];
        busy   <= 1'b1;
        err    <= 1'b0;
      end
      if (state == DECODE) begin
        case (op_q)
          OP_NOP:     ;
          OP_LOAD_LO: cop_wdata[5:0] <= data_q;
          OP_LOAD_HI: begin
            cop_wdata[7:6] <= data_q[1:0];
            cop_addr       <= data_q[4:2];
          end
          OP_EXEC:    cop_op <= data_q[2:0];
          OP_READ:    result <= data_q[0] ? {6'b0, rdata_q[7]} : rdata_q[6:0];
          default:    err <= 1'b1;
        endcase
      end
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT) begin
        if (done_hit) begin
          rdata_q <= cop_rdata;
          result  <= cop_rdata[6:0];
          err     <= cop_err;
        end else if (timeout_hit) begin
          err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
      if (finish) begin
        ack  <= req_q;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pio_cop_sequencer.md
PIO_COP_SEQUENCER -- requirements
Module: pio_cop_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles spent in WAIT (range 1..255).
REQ-002 SHALL have port clk_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pio_cmd, input, 10, HPS command word from saida PIO: [9] req toggle, [8:6] opcode, [5:0] data.
REQ-005 SHALL have port pio_rsp, output, 10, response word to entrada PIO: [9] ack toggle, [8] busy, [7] err, [6:0] result.
REQ-006 SHALL have port cop_start, output, 1, one-cycle start pulse to the coprocessor.
REQ-007 SHALL have port cop_op, output, 3, coprocessor operation code, held stable from cop_start until done or timeout.
REQ-008 SHALL have port cop_addr, output, 3, operand address register.
REQ-009 SHALL have port cop_wdata, output, 8, operand write data register.
REQ-010 SHALL have port cop_done, input, 1, coprocessor completion strobe.
REQ-011 SHALL have port cop_rdata, input, 8, coprocessor result, valid when cop_done=1.
REQ-012 SHALL have port cop_err, input, 1, coprocessor error flag, valid when cop_done=1.

Function
REQ-013 SHALL register pio_cmd into cmd_q every cycle; all decoding uses cmd_q only.
REQ-014 SHALL implement states IDLE, DECODE, ISSUE, WAIT.
REQ-015 SHALL detect a new command in IDLE when cmd_q[9] != ack; it then latches opcode/data, sets busy=1, clears err, and enters DECODE.
REQ-016 SHALL ignore pio_cmd changes outside IDLE; toggling req twice before ack drops a command (HPS must wait for ack == req).
REQ-017 SHALL, in DECODE, perform local opcodes and return to IDLE in one cycle: 000 NOP; 001 LOAD_LO cop_wdata[5:0]<=data; 010 LOAD_HI cop_wdata[7:6]<=data[1:0], cop_addr<=data[4:2]; 100 READ result<=data[0]?{6'b0,rdata_q[7]}:rdata_q[6:0].
REQ-018 SHALL, for opcode 011 EXEC, set cop_op<=data[2:0] and enter ISSUE with cop_start=1 for exactly one cycle, then WAIT.
REQ-019 SHALL, for opcodes 101-111, set err=1 and complete as a local command without touching other registers.
REQ-020 SHALL, in WAIT, on cop_done=1 capture rdata_q<=cop_rdata, result<=cop_rdata[6:0], err<=cop_err, and complete.
REQ-021 SHALL count WAIT cycles with an 8-bit counter cleared on WAIT entry; on reaching TIMEOUT without cop_done, set err=1, leave rdata_q unchanged, and complete.
REQ-022 SHALL give cop_done priority over timeout when both occur in the same cycle.
REQ-023 SHALL ignore cop_done outside WAIT.
REQ-024 SHALL complete by setting ack<=req bit of the latched command and busy<=0 in the same edge, returning to IDLE.
REQ-025 SHALL produce ack 3 edges after a pio_cmd toggle for local ops: edge 1 captures cmd_q, edge 2 enters DECODE, edge 3 completes.
REQ-026 SHALL leave result unchanged by NOP, LOAD_LO, LOAD_HI and illegal opcodes.

Reset
REQ-027 SHALL asynchronously force state=IDLE and set pio_rsp=0, cmd_q=0, cop_start=0, cop_op=0, cop_addr=0, cop_wdata=0, rdata_q=0 and the timeout counter to 0.
REQ-028 SHALL abandon an EXEC in progress on reset with no ack issued; a late cop_done after reset is ignored.
REQ-029 SHALL, after reset release, treat pio_cmd[9]=1 as a pending command (ack=0).

Verification
REQ-030 SHALL cover LOAD_LO 0x2A, then LOAD_HI data=0b010110, resulting in cop_wdata=0xAA and cop_addr=5, with ack toggling after each, each 3 cycles after its toggle.
REQ-031 SHALL cover EXEC op=3 with cop_done at the 4th WAIT cycle, cop_rdata=0xC5, cop_err=0: one cop_start pulse occurs, then result=0x45, err=0, and ack toggles; READ data=1 then returns result=1.
REQ-032 SHALL cover EXEC with TIMEOUT=8 and cop_done never asserted: err=1, busy=0 after 8 WAIT cycles, and rdata_q unchanged.
REQ-033 SHALL cover cop_done asserted on the exact timeout cycle: err equals cop_err (0) and the data is captured.
REQ-034 SHALL cover opcode 110: err=1, ack toggles, and cop_wdata, cop_addr and result are unchanged.
REQ-035 SHALL cover reset asserted during WAIT: all outputs 0 immediately, and an EXEC issued afterwards runs normally.
